// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   loader_state_t        LOAD / HOLD / RUN / ERR sequencing states
//   IMEM_DEPTH_DEFAULT    default instruction memory size in words
//   HOLD_CYCLES_DEFAULT   default CPU reset hold after the last write
//   checksum_add()        running program checksum update (mod 2^32)
package imem_loader_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } loader_state_t;

  localparam int IMEM_DEPTH_DEFAULT  = 64;
  localparam int HOLD_CYCLES_DEFAULT = 2;

  // Program checksum is a plain wrapping 32-bit sum of every written word.
  function automatic logic [31:0] checksum_add(input logic [31:0] sum_in,
                                               input logic [31:0] word_in);
    return sum_in + word_in;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Instruction word stream from the host into the loader.
//   in_valid  source -> loader   in_data / in_last are valid
//   in_ready  loader -> source   loader accepts a word this cycle
//   in_data   source -> loader   32-bit instruction word
//   in_last   source -> loader   final word of the program
// Modports: master = word source (host / bench), slave = loader.
interface imem_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Streams a program into instruction memory at word addresses 0,1,2,...
// and holds the CPU in reset until the final word is written plus
// HOLD_CYCLES settle cycles, then releases it.
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous active-low reset
//   in_if        word stream (slave side: in_valid/in_data/in_last in, in_ready out)
//   reload       one-cycle restart request, honoured in RUN and ERR only
//   imem_we      instruction-memory write enable (registered)
//   imem_addr    instruction-memory word address (registered)
//   imem_wdata   instruction-memory write data (registered)
//   cpu_reset    active-high reset to the CPU
//   done         program loaded and CPU running
//   error        sticky overflow: DEPTH words accepted without in_last
//   word_count   words written since the last (re)start
//   checksum     wrapping 32-bit sum of the words written
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH       = IMEM_DEPTH_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      in_if,
  input  logic              reload,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [AW:0]       word_count,
  output logic [31:0]       checksum
);

  localparam int            HCW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(DEPTH - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES);

  loader_state_t  state_r;
  logic           in_ready_r;
  logic [HCW-1:0] hold_cnt_r;
  logic           accept_s;

  assign in_if.in_ready = in_ready_r;
  assign accept_s       = in_if.in_valid & in_ready_r;

  // Loader sequencer: accepts words, drives the memory write port and the CPU reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= LOAD;
      in_ready_r <= 1'b0;
      hold_cnt_r <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0000_0000;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      checksum   <= 32'h0000_0000;
    end else begin
      case (state_r)
        LOAD: begin
          // in_ready_r is still 0 on the first edge after reset, so no word
          // can be accepted before the loader has advertised readiness.
          in_ready_r <= 1'b1;
          imem_we    <= 1'b0;
          if (accept_s) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_count[AW-1:0];
            imem_wdata <= in_if.in_data;
            word_count <= word_count + (AW+1)'(1);
            checksum   <= checksum_add(checksum, in_if.in_data);
            if (in_if.in_last) begin
              state_r    <= HOLD;
              in_ready_r <= 1'b0;
              hold_cnt_r <= '0;
            end else if (word_count == LAST_IDX) begin
              // Memory is now full and the program never ended: the word is
              // still written, but the CPU must not be released.
              state_r    <= ERR;
              in_ready_r <= 1'b0;
              error      <= 1'b1;
            end else begin
              state_r <= LOAD;
            end
          end
        end
        HOLD: begin
          // Counts HOLD_CYCLES settle edges, releasing the CPU on the one after.
          imem_we    <= 1'b0;
          in_ready_r <= 1'b0;
          if (hold_cnt_r == HOLD_LAST) begin
            state_r   <= RUN;
            cpu_reset <= 1'b0;
            done      <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r + HCW'(1);
          end
        end
        RUN, ERR: begin
          // Both terminal states hold their outputs until a reload restarts loading.
          imem_we    <= 1'b0;
          in_ready_r <= 1'b0;
          if (reload) begin
            state_r    <= LOAD;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= 32'h0000_0000;
          end
        end
        default: begin
          // Unreachable encoding: fall back to a safe, CPU-in-reset LOAD.
          state_r    <= LOAD;
          in_ready_r <= 1'b0;
          imem_we    <= 1'b0;
          cpu_reset  <= 1'b1;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS top. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory word addresses starting at 0. It holds the CPU in reset until the last word is written plus a settle period, then releases the CPU. It sits between the host/bench stimulus and the `top` instance: it is the writer feeding the instruction memory that the CPU fetches from.

## Interface
- `DEPTH`, 64: instruction memory size in words; power of two, ≥ 4.
- `HOLD_CYCLES`, 2: cycles `cpu_reset` stays high after the last write; ≥ 1.
- `AW`, $clog2(DEPTH): word-address width; derived, not overridden.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `in_valid`  in  1  `in_data` / `in_last` valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `in_data`  in  32  instruction word.
- `in_last`  in  1  marks the final word of the program.
- `reload`  in  1  single-cycle request to restart loading; honoured in RUN and ERR only.
- `imem_we`  out  1  instruction-memory write enable.
- `imem_addr`  out  AW  word address.
- `imem_wdata`  out  32  write data.
- `cpu_reset`  out  1  active-high reset to the CPU `top`.
- `done`  out  1  program loaded, CPU running.
- `error`  out  1  overflow: DEPTH words accepted without `in_last`.
- `word_count`  out  AW+1  words written since last (re)start.
- `checksum`  out  32  modulo-2^32 sum of all words written.

## Operation
- States: LOAD, HOLD, RUN, ERR.
- Reset values: state LOAD, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0, `word_count`=0, `checksum`=0. `in_ready` rises on the first edge after reset deasserts.
- LOAD: `in_ready`=1. An accept (`in_valid & in_ready`) registers `imem_we`=1, `imem_addr`=`word_count[AW-1:0]`, `imem_wdata`=`in_data`. `word_count` increments and `checksum` += `in_data`. With no accept, `imem_we`=0.
- Accept with `in_last`=1: go to HOLD, `in_ready`=0.
- Accept with `in_last`=0 when `word_count`==DEPTH-1: the word is still written, then go to ERR with `in_ready`=0 and `error`=1.
- HOLD: counts HOLD_CYCLES cycles with `cpu_reset`=1, then goes to RUN.
- RUN: `cpu_reset`=0, `done`=1, `in_ready`=0. Inputs ignored except `reload`.
- ERR: `cpu_reset`=1, `error`=1. `error` is sticky until `reload` or reset.
- `reload` in RUN/ERR: next state LOAD. `cpu_reset`=1, `done`=0, `error`=0, `word_count`=0, `checksum`=0, `in_ready`=1 the following cycle. `reload` is ignored in LOAD/HOLD.
- Asynchronous reset mid-load: all outputs return to their reset values immediately. A partially written memory is not cleared.

## Timing
- Word accepted at edge N: write strobe visible in cycle N→N+1 (1-cycle latency). `word_count`/`checksum` update at edge N.
- Back-to-back accepts give one write per cycle; throughput 1 word/cycle.
- Last word accepted at edge N: `in_ready` is 0 from N. `cpu_reset` falls and `done` rises at edge N+HOLD_CYCLES+1.
- `reload` sampled at edge M: `cpu_reset` is 1 from M. `in_ready` is 1 from M+1.
- `error` rises at the same edge the overflowing word is accepted.

## Structure
- Shared package `imem_loader_pkg`: state enum `loader_state_t` {LOAD, HOLD, RUN, ERR}; default constants `IMEM_DEPTH_DEFAULT`=64 and `HOLD_CYCLES_DEFAULT`=2.
- Single module. No sub-module is needed: the hold counter and address counter are inline. Instruction-memory write port is the external `imem_*` bus.

## Test plan
- Load 0x20020005, 0x2003000c, 0xac020054(last), back-to-back → writes at addr 0, 1, 2; `word_count`=3; `checksum`=0xEC070065; `cpu_reset` falls 3 cycles after the last accept; `done`=1.
- Same program with `in_valid` gaps of 2 cycles between words → identical writes and checksum; no write strobe during the gaps.
- DEPTH=4, send 4 words, none marked last → 4 writes at addr 0–3; `error`=1 on the 4th accept; `cpu_reset` stays 1; `in_ready`=0.
- RUN, pulse `reload`, load 1 word 0x00000000(last) → `cpu_reset` 1 during reload; `word_count`=1; `checksum`=0; `done` re-asserts.
- Assert `reset`=0 after 2 of 3 words → `imem_we`, counters and `checksum` go to 0 asynchronously; after release, loading restarts at addr 0.
- `reload` pulsed during LOAD and during HOLD → ignored; HOLD length unchanged.
